// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM behind a stall-based request bus.
// Optional out-of-range detection is compiled in with `define DMEM_ERR_EN.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stallreq_o,
  output logic        err_o,
  output logic [1:0]  dbg_state
);

  // Handshake: the initiator raises ce_i and holds ce_i/we_i/addr_i/sel_i/data_i
  // stable while stallreq_o=1; the access completes in the cycle where
  // stallreq_o drops (DONE), and the pipeline advances on the following edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              latch_en;
  logic              do_access;
  logic              wr_en;

  logic [ADDR_W-1:0] lat_idx;
  logic              lat_we;
  logic [3:0]        lat_sel;
  logic [31:0]       lat_data;
  logic              lat_oor;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    latch_en  = 1'b0;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (ce_i) begin
          state_nx = BUSY;
          cnt_nx   = 4'(WAIT_CYCLES);
          latch_en = 1'b1;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          do_access = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      lat_idx  <= '0;
      lat_we   <= 1'b0;
      lat_sel  <= 4'd0;
      lat_data <= 32'd0;
      data_o   <= 32'd0;
      err_o    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (latch_en) begin
        lat_idx  <= addr_i[ADDR_W+1:2];
        lat_we   <= we_i;
        lat_sel  <= sel_i;
        lat_data <= data_i;
      end
      if (do_access && !lat_we) begin
        data_o <= lat_oor ? 32'd0 : mem[lat_idx];
      end
      // err_o is only ever high in the DONE cycle that follows the access edge.
      err_o <= do_access && lat_oor;
    end
  end

`ifdef DMEM_ERR_EN
  logic unused_addr;
  assign unused_addr = ^addr_i[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_oor <= 1'b0;
    end else if (latch_en) begin
      lat_oor <= |addr_i[31:ADDR_W+2];
    end
  end
`else
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};
  assign lat_oor     = 1'b0;
`endif

  // The RAM has no reset; a reset during BUSY returns state to IDLE so wr_en never fires.
  assign wr_en = do_access && lat_we && !lat_oor;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (lat_sel[3]) mem[lat_idx][31:24] <= lat_data[31:24];
      if (lat_sel[2]) mem[lat_idx][23:16] <= lat_data[23:16];
      if (lat_sel[1]) mem[lat_idx][15:8]  <= lat_data[15:8];
      if (lat_sel[0]) mem[lat_idx][7:0]   <= lat_data[7:0];
    end
  end

  assign stallreq_o = !rst && ((state == IDLE && ce_i) || state == BUSY);
  assign dbg_state  = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: random and directed accesses checked against a
// byte-addressed reference memory through an expected-response queue.
module tb_dmem_responder;

  localparam int AW = 10;
  localparam int WC = 1;
  localparam int unsigned SPAN = 32'd1 << (AW + 2);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] data_o;
  logic        stallreq_o;
  logic        err_o;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  // {is_write, err, data_o expected in DONE}
  logic [33:0] exp_q[$];

  logic [7:0]  ref_mem [int unsigned];
  logic [31:0] last_read = 32'd0;

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .ce_i      (ce),
    .we_i      (we),
    .addr_i    (addr),
    .sel_i     (sel),
    .data_i    (wdata),
    .data_o    (data_o),
    .stallreq_o(stallreq_o),
    .err_o     (err_o),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference memory: byte offset 0 of a word is data[31:24].
  function automatic logic [33:0] model(input logic w, input logic [31:0] a,
                                        input logic [3:0] s, input logic [31:0] d);
    logic        oor;
    int unsigned base;
    logic [31:0] word;
    oor = 1'b0;
`ifdef DMEM_ERR_EN
    oor = (a >= SPAN);
`endif
    base = (a % SPAN) & ~32'd3;
    if (w) begin
      if (!oor)
        for (int k = 0; k < 4; k++)
          if (s[3-k]) ref_mem[base + 32'(k)] = d[31-8*k -: 8];
    end else begin
      word = 32'd0;
      if (!oor)
        for (int k = 0; k < 4; k++) word[31-8*k -: 8] = ref_mem[base + 32'(k)];
      last_read = word;
    end
    return {w, oor, last_read};
  endfunction

  // Called just after a rising edge; returns just after the edge that leaves DONE.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, input bit hold_ce);
    int n;
    ce = 1'b1; we = w; addr = a; sel = s; wdata = d;
    exp_q.push_back(model(w, a, s, d));
    n = 0;
    @(negedge clk);
    while (stallreq_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL access_timeout stall still high after %0d cycles addr=%h", n, a);
    end
    @(posedge clk);
    #1;
    if (!hold_ce) ce = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    ce = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: DONE is the stall-low cycle that ends a run of stall-high cycles.
  int          run_len = 0;
  logic [31:0] held = 32'd0;
  logic [33:0] e;

  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
      held = 32'd0;
    end else if (stallreq_o) begin
      run_len++;
      check("hold_data_busy", data_o, held);
      check("err_busy", {31'd0, err_o}, 32'd0);
    end else if (run_len != 0) begin
      check("stall_len", run_len, WC + 2);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=one_response required=none data_o=%h", data_o);
      end else begin
        e = exp_q.pop_front();
        check("done_data", data_o, e[31:0]);
        check("done_err", {31'd0, err_o}, {31'd0, e[32]});
        held = e[31:0];
      end
      run_len = 0;
    end else begin
      check("hold_data_idle", data_o, held);
      check("err_idle", {31'd0, err_o}, 32'd0);
    end
  end

  initial begin
    logic [31:0] a, hi;
    logic        w;
    bit          hold;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle
    repeat (5) begin
      @(negedge clk);
      check("reset_stall", {31'd0, stallreq_o}, 32'd0);
      check("reset_data", data_o, 32'd0);
      check("reset_err", {31'd0, err_o}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Preload words 0x00..0x40 so every later read has known contents
    for (int i = 0; i <= 16; i++) do_access(1'b1, 32'(i * 4), 4'b1111, $urandom, 1'b0);

    // Full write then read
    do_access(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 1'b0);
    idle_cycles(1);
    do_access(1'b0, 32'h10, 4'b0000, 32'h0, 1'b0);
    check("read_deadbeef_model", last_read, 32'hDEADBEEF);

    // Byte-lane writes
    do_access(1'b1, 32'h20, 4'b1111, 32'h11223344, 1'b0);
    do_access(1'b1, 32'h20, 4'b0100, 32'hAAAAAAAA, 1'b0);
    do_access(1'b0, 32'h20, 4'b1111, 32'h0, 1'b0);
    check("lane_read1_model", last_read, 32'h11AA3344);
    do_access(1'b1, 32'h20, 4'b0011, 32'h55665566, 1'b0);
    do_access(1'b0, 32'h20, 4'b1111, 32'h0, 1'b0);
    check("lane_read2_model", last_read, 32'h11AA5566);

    // Back-to-back with ce held high, including an identical repeated request
    do_access(1'b1, 32'h24, 4'b1111, 32'h01020304, 1'b1);
    do_access(1'b1, 32'h24, 4'b0001, 32'h000000FF, 1'b1);
    do_access(1'b0, 32'h24, 4'b1111, 32'h0, 1'b1);
    do_access(1'b0, 32'h24, 4'b1111, 32'h0, 1'b0);

    // sel=0000 write leaves the word intact
    do_access(1'b1, 32'h28, 4'b0000, 32'hFFFFFFFF, 1'b0);
    do_access(1'b0, 32'h28, 4'b1111, 32'h0, 1'b0);

    // Async reset mid-access: the write to 0x40 must never land
    ce = 1'b1; we = 1'b1; addr = 32'h40; sel = 4'b1111; wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    check("busy_stall_before_reset", {31'd0, stallreq_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("stall_falls_on_reset", {31'd0, stallreq_o}, 32'd0);
    ce = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    last_read = 32'd0;
    idle_cycles(2);
    do_access(1'b0, 32'h40, 4'b1111, 32'h0, 1'b0);

    // High address bits: wrap without the error feature, error response with it
    do_access(1'b1, 32'h00001000, 4'b1111, 32'h77778888, 1'b0);
    do_access(1'b0, 32'h0, 4'b1111, 32'h0, 1'b0);
    do_access(1'b0, 32'h00001000, 4'b1111, 32'h0, 1'b0);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      a = 32'($urandom_range(0, 16) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        hi = $urandom & ~(SPAN - 1);
        if (hi == 32'd0) hi = SPAN;
        a = a | hi;
      end
      w = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 2) == 0);
      do_access(w, a, 4'($urandom_range(0, 15)), $urandom, hold);
      if (!hold) idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(4);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
